// File: rtl/register_scanner_pkg.sv
// Shared types for the register scanner: FSM state encoding and scan depth helper.
package register_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4
    } scan_state_t;

    function automatic int depth(input int bus);
        return 32'sd1 << bus;
    endfunction

endpackage

// File: rtl/register_scanner_if.sv
// Bank read port plus outgoing valid/ready word stream of the register scanner.
interface register_scanner_if #(
    parameter int Bits = 8,
    parameter int Bus  = 2
);
    logic [Bus-1:0]  A;
    logic [Bits-1:0] RD;
    logic [Bits-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    modport master (output A, out_data, out_valid, input RD, out_ready);
    modport slave  (input A, out_data, out_valid, output RD, out_ready);
endinterface

// File: rtl/register_scanner_scan_addr_counter.sv
// Bus-bit scan address counter with clear, increment and last-address flag.
module scan_addr_counter
    import register_pkg::*;
#(
    parameter int Bus = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           inc,
    output logic [Bus-1:0] count,
    output logic           last
);
    localparam logic [Bus-1:0] LAST_ADDR = Bus'(depth(Bus) - 32'sd1);

    logic [Bus-1:0] count_r;

    // Address register; saturates at the last address instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {Bus{1'b0}};
        end else if (clear) begin
            count_r <= {Bus{1'b0}};
        end else if (inc && (count_r != LAST_ADDR)) begin
            count_r <= count_r + Bus'(32'd1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign last  = (count_r == LAST_ADDR);
endmodule

// File: rtl/register_scanner.sv
// Walks every bank address once per start pulse and streams each word out.
// Define REGISTER_SCANNER_CHECKSUM_EN to append a modulo-2**Bits sum word per scan.
module register_scanner
    import register_pkg::*;
#(
    parameter int Bits = 8,
    parameter int Bus  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    register_scanner_if.master   bus,
    output logic                 busy,
    output logic                 done
);
    scan_state_t     state_r, next_state_s;
    logic            clear_s, inc_s, last_s, hs_s;
    logic [Bus-1:0]  addr_s;
    logic [Bits-1:0] out_data_r;
    logic            out_valid_r, busy_r, done_r;

    scan_addr_counter #(.Bus(Bus)) u_addr (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .inc   (inc_s),
        .count (addr_s),
        .last  (last_s)
    );

    assign hs_s = out_valid_r && bus.out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and counter control.
    always_comb begin
        next_state_s = state_r;
        clear_s      = 1'b0;
        inc_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = FETCH;
                    clear_s      = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: next_state_s = SEND;
            SEND: begin
                if (hs_s && last_s) begin
`ifdef REGISTER_SCANNER_CHECKSUM_EN
                    next_state_s = CSUM;
`else
                    next_state_s = DONE;
`endif
                end else if (hs_s) begin
                    inc_s        = 1'b1;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = SEND;
                end
            end
`ifdef REGISTER_SCANNER_CHECKSUM_EN
            CSUM: begin
                if (hs_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = CSUM;
                end
            end
`endif
            DONE: begin
                next_state_s = IDLE;
                clear_s      = 1'b1;
            end
            default: begin
                next_state_s = IDLE;
                clear_s      = 1'b1;
            end
        endcase
    end

`ifdef REGISTER_SCANNER_CHECKSUM_EN
    logic [Bits-1:0] sum_r;

    // Running sum of every word captured in FETCH, restarted on each scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_r <= {Bits{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            sum_r <= {Bits{1'b0}};
        end else if (state_r == FETCH) begin
            sum_r <= sum_r + bus.RD;
        end else begin
            sum_r <= sum_r;
        end
    end
`endif

    // Output word register: captured in FETCH, held until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r  <= {Bits{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    out_data_r  <= bus.RD;
                    out_valid_r <= 1'b1;
                end
                SEND: begin
                    if (hs_s) begin
                        out_valid_r <= 1'b0;
                    end
                end
`ifdef REGISTER_SCANNER_CHECKSUM_EN
                CSUM: begin
                    if (hs_s) begin
                        out_valid_r <= 1'b0;
                    end else if (!out_valid_r) begin
                        out_data_r  <= sum_r;
                        out_valid_r <= 1'b1;
                    end
                end
`endif
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    // Status flags registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            done_r <= (next_state_s == DONE);
        end
    end

    assign bus.A         = addr_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign busy          = busy_r;
    assign done          = done_r;
endmodule

// File: tb/tb_register_scanner.sv
// Directed self-checking bench for register_scanner (Bits=8, Bus=2).
module tb_register_scanner;

`ifdef REGISTER_SCANNER_CHECKSUM_EN
    localparam int NW = 5;
`else
    localparam int NW = 4;
`endif

    logic clk = 1'b0;
    logic reset, start, busy, done;
    logic [7:0] bank [4];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0] got_q [$];
    logic [1:0] addr_q [$];

    logic [7:0] exp_basic [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    logic [7:0] exp_ff    [5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
    logic [1:0] exp_addr  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

    register_scanner_if #(.Bits(8), .Bus(2)) bus ();

    register_scanner #(.Bits(8), .Bus(2)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    assign bus.RD = bank[bus.A];

    always #5 clk = ~clk;

    // Record every accepted word, its address, and every done cycle.
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            addr_q.push_back(bus.A);
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int n_in, output int n_out, output bit ok);
        n_out = n_in;
        ok = 1'b0;
        while (n_out < 80) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            n_out++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; bus.out_ready = 1'b1;
        bank = '{8'h11, 8'h22, 8'h33, 8'h44};
        tick(); tick();
        checks++; if (bus.A !== 2'd0) begin failures++; $display("FAIL reset_A got=%0h exp=0", bus.A); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.out_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        start = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_during_reset_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_basic;
        int base, d0, n;
        bit ok;
        base = got_q.size(); d0 = done_cnt;
        start = 1'b1; tick(); n = 1; start = 1'b0;
        checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.A !== 2'd0) begin
            failures++; $display("FAIL basic_fetch busy=%0b valid=%0b A=%0d exp 1/0/0", busy, bus.out_valid, bus.A); end
        tick(); n = 2;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin
            failures++; $display("FAIL basic_first_word valid=%0b data=%0h exp 1/11", bus.out_valid, bus.out_data); end
        wait_done(n, n, ok);
        checks++; if (!ok || n != 2*NW+1) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=%0d", n, 2*NW+1); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || bus.A !== 2'd0) begin
            failures++; $display("FAIL basic_after done=%0b busy=%0b A=%0d exp 0/0/0", done, busy, bus.A); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (got_q.size() - base != NW) begin failures++; $display("FAIL basic_word_count got=%0d exp=%0d", got_q.size() - base, NW); end
        for (int i = 0; i < NW && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_basic[i] || addr_q[base+i] !== exp_addr[i]) begin
                failures++; $display("FAIL basic_word%0d data=%0h A=%0d exp %0h/%0d", i, got_q[base+i], addr_q[base+i], exp_basic[i], exp_addr[i]); end
        end
    endtask

    task automatic test_stall;
        int base, n;
        bit ok;
        base = got_q.size();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); n = 4;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22) begin
            failures++; $display("FAIL stall_pre valid=%0b data=%0h exp 1/22", bus.out_valid, bus.out_data); end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); n++;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22 || bus.A !== 2'd1) begin
                failures++; $display("FAIL stall_hold%0d valid=%0b data=%0h A=%0d exp 1/22/1", i, bus.out_valid, bus.out_data, bus.A); end
        end
        bus.out_ready = 1'b1;
        wait_done(n, n, ok);
        checks++; if (!ok || n != 2*NW+6) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=%0d", n, 2*NW+6); end
        tick();
        checks++; if (got_q.size() - base != NW) begin failures++; $display("FAIL stall_word_count got=%0d exp=%0d", got_q.size() - base, NW); end
        for (int i = 0; i < NW && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_basic[i]) begin
                failures++; $display("FAIL stall_word%0d got=%0h exp=%0h", i, got_q[base+i], exp_basic[i]); end
        end
    endtask

    task automatic test_start_ignored;
        int base, d0, n;
        bit ok;
        base = got_q.size(); d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        tick(); start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); start = 1'b1; tick(); start = 1'b0; n = 6;
        wait_done(n, n, ok);
        checks++; if (!ok || n != 2*NW+1) begin failures++; $display("FAIL ignore_done_cycle got=%0d exp=%0d", n, 2*NW+1); end
        tick(); tick(); tick();
        checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            failures++; $display("FAIL ignore_single_done dones=%0d busy=%0b exp 1/0", done_cnt - d0, busy); end
        checks++; if (got_q.size() - base != NW) begin failures++; $display("FAIL ignore_word_count got=%0d exp=%0d", got_q.size() - base, NW); end
        base = got_q.size();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(1, n, ok);
        tick();
        checks++; if (!ok || got_q.size() - base != NW) begin failures++; $display("FAIL rescan_word_count got=%0d exp=%0d", got_q.size() - base, NW); end
        if (got_q.size() > base) begin
            checks++; if (got_q[base] !== 8'h11 || addr_q[base] !== 2'd0) begin
                failures++; $display("FAIL rescan_first data=%0h A=%0d exp 11/0", got_q[base], addr_q[base]); end
        end
    endtask

    task automatic test_reset_mid;
        int base, d0, n;
        bit ok;
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        checks++; if (bus.A !== 2'd2 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h33) begin
            failures++; $display("FAIL mid_pre A=%0d valid=%0b data=%0h exp 2/1/33", bus.A, bus.out_valid, bus.out_data); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.A !== 2'd0 || done !== 1'b0) begin
            failures++; $display("FAIL mid_abort valid=%0b busy=%0b A=%0d done=%0b exp 0/0/0/0", bus.out_valid, busy, bus.A, done); end
        repeat (3) tick();
        checks++; if (done_cnt - d0 != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_no_done dones=%0d busy=%0b exp 0/0", done_cnt - d0, busy); end
        base = got_q.size();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(1, n, ok);
        tick();
        checks++; if (!ok || got_q.size() - base != NW) begin failures++; $display("FAIL mid_rescan_count got=%0d exp=%0d", got_q.size() - base, NW); end
        if (got_q.size() > base) begin
            checks++; if (got_q[base] !== 8'h11 || addr_q[base] !== 2'd0) begin
                failures++; $display("FAIL mid_rescan_first data=%0h A=%0d exp 11/0", got_q[base], addr_q[base]); end
        end
    endtask

    task automatic test_ff_wrap;
        int base, n;
        bit ok;
        bank = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        base = got_q.size();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(1, n, ok);
        checks++; if (!ok || n != 2*NW+1) begin failures++; $display("FAIL ff_done_cycle got=%0d exp=%0d", n, 2*NW+1); end
        tick();
        checks++; if (got_q.size() - base != NW) begin failures++; $display("FAIL ff_word_count got=%0d exp=%0d", got_q.size() - base, NW); end
        for (int i = 0; i < NW && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_ff[i]) begin
                failures++; $display("FAIL ff_word%0d got=%0h exp=%0h", i, got_q[base+i], exp_ff[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_ff_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
